// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// byte width and the default requester count.
package uart_pkg;

  localparam int unsigned ByteW       = 8;
  localparam int unsigned DefaultNReq = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGuard = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search. The requester just after ptr has top
// priority, wrapping modulo N_REQ; ptr itself has lowest priority.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Two ascending passes: first the indices above ptr, then the wrap-around part.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (!valid && (j > int'(ptr)) && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (!valid && (j <= int'(ptr)) && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte-stream requesters with round-robin
// arbitration. Optional packet locking (macro UART_ARB_PKTLOCK_EN) keeps a
// multi-byte packet from being interleaved with other requesters' bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = DefaultNReq,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [ByteW*N_REQ-1:0] data,
  input  logic [N_REQ-1:0]       last,
  output logic [N_REQ-1:0]       ack,
  output logic                   tx_wr_en,
  output logic [ByteW-1:0]       tx_byte,
  input  logic                   tx_empty,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] owner_q;
  logic [N_REQ-1:0] ack_q;
  logic             wr_q;
  logic [ByteW-1:0] byte_q;
  logic             busy_q;
  logic             lock_q;

  logic [N_REQ-1:0] owner_oh;
  logic             owner_req;
  logic             lock_hold;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [ByteW-1:0] win_byte;
  logic             load;

  // Decode the current owner and decide whether the lock still applies.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      owner_oh[i] = (owner_q == IDX_W'(i));
    end
  end

  assign owner_req = |(req & owner_oh);
  // A lock whose owner has dropped req is an abandoned packet: fall back to round-robin.
  assign lock_hold = lock_q & owner_req;
  assign elig      = lock_hold ? (req & owner_oh) : req;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr (
    .req  (elig),
    .ptr  (ptr_q),
    .grant(win_oh),
    .idx  (win_idx),
    .valid(win_valid)
  );

  // Select the winning requester's byte from the flattened data bus.
  always_comb begin
    win_byte = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_oh[i]) begin
        win_byte = data[i*ByteW +: ByteW];
      end
    end
  end

  assign load = (state_q == StIdle) && tx_empty && win_valid;

`ifdef UART_ARB_PKTLOCK_EN
  logic win_last;
  assign win_last = |(last & win_oh);

  // Lock follows the last flag of each granted byte; an abandoned packet releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= 1'b0;
    end else if (load) begin
      lock_q <= ~win_last;
    end else if ((state_q == StIdle) && lock_q && !owner_req) begin
      lock_q <= 1'b0;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;
  assign lock_q      = 1'b0;
`endif

  // Main FSM: grant in IDLE, one blind GUARD cycle, then WAIT for uart_tx to drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
      ack_q   <= '0;
      wr_q    <= 1'b0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      wr_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load) begin
            byte_q  <= win_byte;
            ack_q   <= win_oh;
            wr_q    <= 1'b1;
            owner_q <= win_idx;
            busy_q  <= 1'b1;
            if (!lock_hold) begin
              ptr_q <= win_idx;
            end
            state_q <= StGuard;
          end
        end
        // uart_tx status lags the write strobe by a cycle, so tx_empty is ignored here.
        StGuard: state_q <= StWait;
        StWait: begin
          if (tx_empty) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack      = ack_q;
  assign tx_wr_en = wr_q;
  assign tx_byte  = byte_q;
  assign busy     = busy_q;
  assign owner    = owner_q;

endmodule
